// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for uart_tx_arbiter: per-requester req/data with
// ack, plus frame status (owner, busy, done).
interface uart_tx_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
);
   localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] data;
   logic [NREQ-1:0]        ack;
   logic [OWN_W-1:0]       owner;
   logic                   busy;
   logic                   done;

   modport master (
      output req, data,
      input  ack, owner, busy, done
   );

   modport slave (
      input  req, data,
      output ack, owner, busy, done
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter, one bit per tx_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_tick,
   uart_tx_arbiter_if.slave bus,
   output logic             txd
);
   localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP, PAR} state_t;
`else
   typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

   state_t              state_q, state_n;
   logic [DATA_W-1:0]   shift_q, shift_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [OWN_W-1:0]    ptr_q, ptr_n;
   logic [OWN_W-1:0]    owner_q, owner_n;
   logic [NREQ-1:0]     ack_q, ack_n;
   logic                done_q, done_n;
   logic                busy_q, busy_n;
   logic                txd_q, txd_n;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_n;
`endif

   logic                any_req;
   logic                found;
   logic                grant;
   logic [OWN_W-1:0]    cand;
   logic [OWN_W-1:0]    win;
   logic [OWN_W-1:0]    win_next;
   logic [DATA_W-1:0]   win_data;

   // Rotating search: first asserted req at or after the pointer, modulo NREQ.
   always_comb begin
      any_req = |bus.req;
      found   = 1'b0;
      cand    = '0;
      win     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = OWN_W'((32'(ptr_q) + k) % 32'(NREQ));
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_data = bus.data[win*DATA_W +: DATA_W];
      win_next = (win == OWN_W'(NREQ - 1)) ? '0 : win + 1'b1;
   end

   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      cnt_n   = cnt_q;
      ptr_n   = ptr_q;
      owner_n = owner_q;
      txd_n   = txd_q;
      ack_n   = '0;
      done_n  = 1'b0;
      grant   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = par_q;
`endif
      case (state_q)
         IDLE: if (any_req) begin
            grant   = 1'b1;
            state_n = ARM;
         end
         ARM: if (tx_tick) begin
            txd_n   = 1'b0;
            state_n = START;
         end
         START: if (tx_tick) begin
            txd_n   = shift_q[0];
            shift_n = shift_q >> 1;
            cnt_n   = '0;
            state_n = DATA;
         end
         DATA: if (tx_tick) begin
            if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               txd_n   = par_q;
               state_n = PAR;
`else
               txd_n   = 1'b1;
               state_n = STOP;
`endif
            end else begin
               txd_n   = shift_q[0];
               shift_n = shift_q >> 1;
               cnt_n   = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PAR: if (tx_tick) begin
            txd_n   = 1'b1;
            state_n = STOP;
         end
`endif
         STOP: if (tx_tick) begin
            done_n = 1'b1;
            // Re-arbitrate on the stop edge so the next start bit follows with no idle gap.
            if (any_req) begin
               grant   = 1'b1;
               txd_n   = 1'b0;
               state_n = START;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (grant) begin
         shift_n = win_data;
         ack_n   = NREQ'(1) << win;
         owner_n = win;
         ptr_n   = win_next;
`ifdef UART_TX_PARITY_EN
         par_n   = ^win_data;
`endif
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         ack_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         ptr_q   <= ptr_n;
         owner_q <= owner_n;
         ack_q   <= ack_n;
         done_q  <= done_n;
         busy_q  <= busy_n;
         txd_q   <= txd_n;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_n;
`endif
      end
   end

   assign bus.ack   = ack_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign txd       = txd_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random request sets,
// checked against a frame-level model of the round-robin UART scheduler.
module tb_uart_tx_arbiter;
   localparam int NREQ   = 4;
   localparam int DATA_W = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FL = DATA_W + 3;
`else
   localparam int FL = DATA_W + 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_tick = 1'b0;
   logic txd;

   uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_tick (tx_tick),
      .bus     (bus),
      .txd     (txd)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [NREQ-1:0]   rq   = '0;
   logic [NREQ-1:0]   hold = '0;
   logic [DATA_W-1:0] byte_m [NREQ];
   int ptr_m = 0;
   int tp    = 16;
   int phase = 0;
   bit last_tick;

   assign bus.req = rq;
   always_comb begin
      bus.data = '0;
      for (int i = 0; i < NREQ; i++) bus.data[i*DATA_W +: DATA_W] = byte_m[i];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: outputs sampled 1 time unit after the edge; tick scheduled for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
      last_tick = tx_tick;
      phase     = (phase + 1) % tp;
      tx_tick   = (phase == 0);
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic exp_bit(input logic [DATA_W-1:0] b, input int k);
      logic [DATA_W-1:0] t;
      if (k == 0) return 1'b0;
      if (k <= DATA_W) begin
         t = b >> (k - 1);
         return t[0];
      end
`ifdef UART_TX_PARITY_EN
      if (k == DATA_W + 1) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic wait_tick(output bit ok);
      logic prev;
      bit quiet;
      prev  = txd;
      quiet = 1'b1;
      ok    = 1'b0;
      for (int n = 0; n < 64; n++) begin
         step();
         if (last_tick) begin
            ok = 1'b1;
            break;
         end
         if (txd !== prev || bus.ack !== '0 || bus.done !== 1'b0) quiet = 1'b0;
      end
      check("quiet_between_ticks", quiet, 1);
      if (!ok) check("tick_timeout", 0, 1);
   endtask

   // Serves frames from IDLE until the arbiter returns to IDLE; req must be set beforehand.
   task automatic serve(input logic [NREQ-1:0] raise_mask, input int raise_frame, input int release_frame);
      int w;
      bit chained;
      bit ok;
      logic [DATA_W-1:0] b;
      chained = 1'b0;
      step();
      for (int f = 0; f < 32; f++) begin
         w = pick(rq, ptr_m);
         check("ack_onehot", bus.ack, 32'(1) << w);
         check("owner", bus.owner, w);
         check("busy_in_frame", bus.busy, 1);
         if (!chained) check("txd_at_ack", txd, 1);
         b     = byte_m[w];
         ptr_m = (w + 1) % NREQ;
         if (f == release_frame) hold = '0;
         if (!hold[w]) rq[w] = 1'b0;
         for (int k = 0; k < FL; k++) begin
            if (!(chained && k == 0)) begin
               wait_tick(ok);
               if (!ok) return;
               check("done_early", bus.done, 0);
            end
            check("txd_bit", txd, exp_bit(b, k));
            if (f == raise_frame && k == 4) rq = rq | raise_mask;
         end
         wait_tick(ok);
         if (!ok) return;
         check("done_pulse", bus.done, 1);
         chained = (rq != '0);
         check("busy_after_stop", bus.busy, chained);
         if (!chained) begin
            check("txd_idle", txd, 1);
            step();
            check("done_one_cycle", bus.done, 0);
            return;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) byte_m[i] = '0;
      #2 rst = 1'b0;
      repeat (3) step();
      check("rst_txd", txd, 1);
      check("rst_ack", bus.ack, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_owner", bus.owner, 0);
      rst = 1'b1;
      repeat (2) step();

      // Single request from requester 2 with 0xA5.
      byte_m[2] = 8'hA5;
      rq = 4'b0100;
      serve('0, -1, -1);

      // Pointer back to 0, all four requesting.
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      ptr_m = 0;
      step();
      byte_m[0] = 8'h11; byte_m[1] = 8'h22; byte_m[2] = 8'h33; byte_m[3] = 8'h44;
      rq = 4'b1111;
      serve('0, -1, -1);

      // Requester 0 holds req; requester 3 joins mid-frame and must win next.
      byte_m[0] = DATA_W'($urandom);
      byte_m[3] = DATA_W'($urandom);
      hold = 4'b0001;
      rq   = 4'b0001;
      serve(4'b1000, 0, 2);

      // req[1] rises together with a tick: that tick must not start the frame.
      for (int n = 0; n < 64 && !tx_tick; n++) step();
      if (!tx_tick) check("coincide_setup_timeout", 0, 1);
      byte_m[1] = DATA_W'($urandom);
      rq[1] = 1'b1;
      serve('0, -1, -1);

      // Reset during data bit 4, then re-arbitration from pointer 0.
      begin
         bit ok;
         logic [DATA_W-1:0] b;
         b = DATA_W'($urandom);
         byte_m[1] = b;
         rq[1] = 1'b1;
         step();
         check("mid_ack", bus.ack, 4'b0010);
         rq[1] = 1'b0;
         for (int k = 0; k < 6; k++) wait_tick(ok);
         check("mid_bit4", txd, exp_bit(b, 5));
         step();
         #2 rst = 1'b0;
         #1;
         check("mid_rst_txd", txd, 1);
         check("mid_rst_busy", bus.busy, 0);
         check("mid_rst_ack", bus.ack, 0);
         check("mid_rst_done", bus.done, 0);
         byte_m[1] = DATA_W'($urandom);
         byte_m[2] = DATA_W'($urandom);
         rq = 4'b0110;
         repeat (3) step();
         check("held_rst_ack", bus.ack, 0);
         rst = 1'b1;
         ptr_m = 0;
         serve('0, -1, -1);
      end

`ifdef UART_TX_PARITY_EN
      byte_m[0] = 8'h07;
      rq = 4'b0001;
      serve('0, -1, -1);
`endif

      // Random request sets, bytes, late joiners and tick periods.
      for (int r = 0; r < 8; r++) begin
         tp      = $urandom_range(2, 20);
         phase   = 0;
         tx_tick = 1'b0;
         step();
         for (int i = 0; i < NREQ; i++) byte_m[i] = DATA_W'($urandom);
         rq = NREQ'($urandom_range(1, 15));
         serve(NREQ'($urandom_range(0, 15)), $urandom_range(0, 2), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin scheduler that shares one serial UART transmit line between `NREQ` byte requesters.
- Accepts a byte from the winning requester and serialises it as a standard 8N1 frame, one bit per `tx_tick` pulse from the baud clock generator.
- Sits between the generator's `tx_clk` output and the pin-level `txd`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: bits per frame payload.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `tx_tick`  input  1  one-`clk`-wide bit-rate pulse; driven by the baud generator's `tx_clk`.
- `req`  input  NREQ  per-requester transmit request; level; held until acked.
- `data`  input  NREQ*DATA_W  per-requester byte; slice `i` is `data[i*DATA_W +: DATA_W]`; stable while `req[i]` is high.
- `ack`  output  NREQ  one-cycle pulse: the byte from requester `i` has been latched.
- `owner`  output  $clog2(NREQ)  index of the requester whose frame is in flight.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when the stop bit completes.
- `txd`  output  1  serial line; idle high.

## Operation
States: IDLE, ARM, START, DATA, STOP (plus PAR with the macro).
- **Reset values:** state=IDLE, `txd`=1, `ack`=0, `done`=0, `busy`=0, `owner`=0, priority pointer=0, bit counter=0.
- **Arbitration (IDLE, any `req` high):**
  - The winner is the first set `req` at or after the pointer, wrapping modulo `NREQ`.
  - On that edge: latch `data` into the shift register, pulse `ack[winner]`, set `owner`=winner, set pointer=(winner+1) mod `NREQ`, go to ARM.
- **ARM:** wait for `tx_tick`; on tick, `txd`←0 and go to START.
- **START:** on tick, `txd`←shift[0], bit counter←0, go to DATA.
- **DATA:**
  - On each tick: shift right (LSB first) and increment the counter.
  - After bit `DATA_W-1` has been held for one tick period, `txd`←1 and go to STOP.
- **STOP:** on tick, pulse `done`.
  - If any `req` is high, arbitrate in that same edge, ack the winner, `txd`←0 and go directly to START. This gives zero idle gap between frames.
  - Otherwise go to IDLE.
- `req` is ignored in ARM, START, DATA, and in STOP cycles without a tick.
- A requester may deassert `req` in the cycle after `ack`. A `req` that drops before being granted is never acked.
- The arbiter has no knowledge of the baud rate; bit timing comes solely from `tx_tick`.

## Timing
- All outputs are registered; `txd` changes only on the `clk` edge that samples `tx_tick`=1.
- Ack latency: `ack` is high in the cycle after the first edge that sees `req` in IDLE.
- Start bit begins on the first tick after ARM is entered. A tick coinciding with the arbitration edge is not consumed.
- Frame length is exactly 1+`DATA_W`+1 tick periods from start-bit edge to the edge that raises `done` (one more with parity).
- Simultaneous requests: exactly one `ack` bit is ever high. Other requesters wait at most `NREQ`-1 frames.
- Reset mid-frame: `txd` goes to 1 asynchronously, the frame is abandoned, and no `ack` or `done` is issued. After release, arbitration restarts with the pointer at 0.
- A `tx_tick` held high for more than one cycle is out of contract.

## Configuration
- `UART_TX_PARITY_EN` defined: a PAR state is inserted between DATA and STOP.
  - `txd` carries the even-parity bit (XOR of the latched byte) for one tick period.
  - Frame length is 11 tick periods when `DATA_W`=8.
- `UART_TX_PARITY_EN` undefined: no PAR state; 8N1 only; the parity logic is absent.

## Test plan
- Single request, with `tx_tick` every 16 clk, `req[2]`=1 and `data`=0xA5:
  - One `ack[2]` pulse; `owner`=2.
  - `txd` sequence per tick: 0,1,0,1,0,0,1,0,1,1.
  - `done` at 10 ticks after the start edge; then IDLE with `busy`=0.
- All four `req` high, pointer 0, bytes 0x11/0x22/0x33/0x44:
  - Acks in order 0,1,2,3.
  - Frames back-to-back with no idle bit.
  - Each `ack` is removed from `req` after it is seen.
- Starvation check: `req[0]` held continuously, `req[3]` raised mid-frame. The next grant after the current frame goes to 3 when the pointer is past 0.
- Reset asserted during DATA bit 4: `txd`=1, `busy`=0 and `ack`=0 immediately. The first grant after release goes to the lowest set `req`.
- Tick-coincidence check: `req[1]` rises in the same cycle as `tx_tick`. `ack[1]` follows on the next cycle, and the start bit begins on the following tick, not the coincident one.
- With `UART_TX_PARITY_EN`, `data`=0x07: the parity bit is 1 and the frame spans 11 ticks.
